// File: rtl/dmem_if.sv
// Load/store request/response bundle between the MEM pipeline stage (master)
// and the data-memory responder (slave).
interface dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        stall;
  logic        fault;

  modport master (
    output req, we, addr, wdata, size, unsigned_ld,
    input  ready, rvalid, rdata, stall, fault
  );

  modport slave (
    input  req, we, addr, wdata, size, unsigned_ld,
    output ready, rvalid, rdata, stall, fault
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM answering MEM-stage loads/stores with programmable wait states.
// Optional feature: define DMEM_MISALIGN_FAULT_EN to flag (and suppress) misaligned half/word accesses.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input logic   Clock,
  input logic   nReset,
  dmem_if.slave bus
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        ready_r;
  logic        rvalid_r;
  logic        fault_r;
  logic [31:0] rdata_r;

  logic          we_p0;
  logic          uns_p0;
  logic [AW-1:0] idx_p0;
  logic [1:0]    lo_p0;
  logic [1:0]    size_p0;
  logic [31:0]   wdata_p0;

  logic [31:0] mem [DEPTH];

  // Byte offset of the addressed lane group; half/word are forced to natural alignment.
  function automatic logic [1:0] lane_off(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   return lo;
      2'b01:   return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   return 4'b0001 << lane_off(sz, lo);
      2'b01:   return 4'b0011 << lane_off(sz, lo);
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [1:0] lo, input logic uns);
    logic        [31:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    sh = word >> {lane_off(sz, lo), 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (sz)
      2'b00: begin
        r = b;
        return uns ? {24'd0, sh[7:0]} : r;
      end
      2'b01: begin
        r = h;
        return uns ? {16'd0, sh[15:0]} : r;
      end
      default: return sh;
    endcase
  endfunction

`ifdef DMEM_MISALIGN_FAULT_EN
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    return ((sz == 2'b01) && lo[0]) || (sz[1] && (lo != 2'b00));
  endfunction
`endif

  // In IDLE the request is served straight from the bus; afterwards from the captured copy.
  logic          is_idle;
  logic          sel_we;
  logic          sel_uns;
  logic [AW-1:0] sel_idx;
  logic [1:0]    sel_lo;
  logic [1:0]    sel_size;
  logic [31:0]   sel_wdata;
  logic          go_resp;
  logic          bad;
  logic          commit;
  logic [3:0]    wr_mask;
  logic [31:0]   wr_lanes;
  logic [31:0]   rd_word;
  logic [31:0]   resp_data;
  logic          unused_addr;

  assign is_idle   = (state == IDLE);
  assign sel_we    = is_idle ? bus.we          : we_p0;
  assign sel_uns   = is_idle ? bus.unsigned_ld : uns_p0;
  assign sel_idx   = is_idle ? bus.addr[AW+1:2] : idx_p0;
  assign sel_lo    = is_idle ? bus.addr[1:0]   : lo_p0;
  assign sel_size  = is_idle ? bus.size        : size_p0;
  assign sel_wdata = is_idle ? bus.wdata       : wdata_p0;

  assign go_resp = (is_idle && bus.req && (WAIT_CYCLES == 0)) ||
                   ((state == WAIT) && (wait_cnt == 4'd0));

`ifdef DMEM_MISALIGN_FAULT_EN
  assign bad = misaligned(sel_size, sel_lo);
`else
  assign bad = 1'b0;
`endif

  assign commit    = go_resp && sel_we && !bad;
  assign wr_mask   = commit ? lane_mask(sel_size, sel_lo) : 4'b0000;
  assign wr_lanes  = lane_data(sel_size, sel_wdata);
  assign rd_word   = mem[sel_idx];
  assign resp_data = (sel_we || bad) ? 32'd0 : load_extend(rd_word, sel_size, sel_lo, sel_uns);

  assign unused_addr = ^bus.addr[31:AW+2];

  assign bus.ready  = ready_r;
  assign bus.rvalid = rvalid_r;
  assign bus.rdata  = rdata_r;
  assign bus.fault  = fault_r;
  assign bus.stall  = (is_idle && bus.req) || (state == WAIT);

  // p0: request capture and RAM byte-lane write on the edge entering RESP
  always_ff @(posedge Clock) begin
    if (is_idle && bus.req) begin
      we_p0    <= bus.we;
      uns_p0   <= bus.unsigned_ld;
      idx_p0   <= bus.addr[AW+1:2];
      lo_p0    <= bus.addr[1:0];
      size_p0  <= bus.size;
      wdata_p0 <= bus.wdata;
    end
    for (int i = 0; i < 4; i++) begin
      if (wr_mask[i]) mem[sel_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
    end
  end

  // Control FSM with registered handshake outputs
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      ready_r  <= 1'b1;
      rvalid_r <= 1'b0;
      rdata_r  <= 32'd0;
      fault_r  <= 1'b0;
    end else begin
      rvalid_r <= 1'b0;
      fault_r  <= 1'b0;
      if (go_resp) begin
        rvalid_r <= 1'b1;
        rdata_r  <= resp_data;
        fault_r  <= bad;
      end
      case (state)
        IDLE: begin
          if (bus.req) begin
            ready_r <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= RESP;
          else wait_cnt <= wait_cnt - 4'd1;
        end
        RESP: begin
          state   <= IDLE;
          ready_r <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

endmodule
